mult_request_arbiter: RTL
=========================

// Module: mult_request_arbiter
// PURPOSE
//  Shares one signed sequential multiplier between two requesters, A and B, and sequences each operation.
//  Arbitration between A and B is round-robin. The block latches the operands of the granted requester
//  and pulses the multiplier start. It then waits for the multiplier ready, returns the product to the
//  owner with a done pulse, and flags an error if the multiplier fails to finish.
//  It sits between the client logic and the multiplier's start/ready/operand/product pins.
// PARAMETERS
//  Word_Length    6   operand width; product width is 2*Word_Length
//  ARM_CYCLES     2   cycles after start during which mul_ready is ignored (covers the start one-shot delay and stale ready)
//  TIMEOUT_CYCLES 64  maximum BUSY cycles before the operation is aborted; must be > Word_Length+ARM_CYCLES
// PORTS
//  clk              in   1      system clock, rising edge
//  reset            in   1      asynchronous reset, active-low
//  req_a            in   1      A request level; hold until gnt_a
//  multiplicand_a   in   WL     A operand, signed; stable while req_a=1
//  multiplier_a     in   WL     A operand, signed
//  req_b / multiplicand_b / multiplier_b   same as A, for B
//  gnt_a, gnt_b     out  1      1-cycle pulse: operands accepted
//  done_a, done_b   out  1      1-cycle pulse: result valid for owner
//  err_a, err_b     out  1      1-cycle pulse together with done_x when the operation timed out
//  result           out  2*WL   signed product of the last completed operation
//  busy             out  1      1 in every state except IDLE
//  mul_start        out  1      1-cycle start pulse to the multiplier
//  mul_multiplicand out  WL     latched operand, held from LAUNCH until next grant
//  mul_multiplier   out  WL     latched operand, held likewise
//  mul_ready        in   1      multiplier ready level
//  mul_product      in   2*WL   multiplier product, valid while mul_ready=1
// BEHAVIOUR
//  Reset (async, reset=0):
//  - state=IDLE; all outputs, operand/result registers and counters = 0
//  - last_owner=B, so A wins the first tie
//  FSM, all outputs registered:
//  - IDLE: if req_a|req_b, pick winner, latch its operands, go to LAUNCH; else stay
//  - LAUNCH (1 cycle): gnt_x=1, mul_start=1; load arm counter; go to ARM
//  - ARM (ARM_CYCLES cycles): mul_ready ignored; go to BUSY; timeout counter=0
//  - BUSY, mul_ready=1: result<=mul_product; go to DONE
//  - BUSY, counter reaches TIMEOUT_CYCLES-1 with no ready: result unchanged; set timeout flag; go to DONE
//  - BUSY, otherwise: counter+1
//  - DONE (1 cycle): done_x=1; err_x=timeout flag; last_owner<=x; clear flag; go to IDLE
//  Arbitration, evaluated in IDLE only:
//  - one requester asserted: it wins
//  - both asserted: the one that is not last_owner wins
//  - a requester that stays asserted after its done loses to a waiting peer
//  Operand handling:
//  - operands are sampled only in the IDLE->LAUNCH cycle; later input changes are ignored
//  - a request dropped before grant is never served; no request is queued
//  - result is held between DONE events; stale mul_ready from a previous operation cannot complete
//    a new one, because of ARM
//  Latency: req seen in IDLE -> gnt at +1 -> done at +3+ARM_CYCLES+N, where N = BUSY cycles
//    until mul_ready. Minimum re-grant gap after DONE is 1 IDLE cycle.
//  Reset mid-operation: abort immediately; no done/err is issued; the multiplier is reset by the
//    same reset net.
//  Simultaneous events:
//  - mul_ready and timeout in the same BUSY cycle: ready wins (err=0)
//  - req changes during LAUNCH..DONE: no effect until IDLE
// TESTING
//  WL=6. A: 5 * -3 alone; model ready after 8 BUSY cycles, product 12'hFF1
//    -> gnt_a at +1, done_a once, result=12'hFF1, err_a=0
//  After reset, req_a=req_b=1 together (A: 7*7, B: -32*-32)
//    -> A served first (result=49); then B (result=1024); gnt pulses never overlap
//  req_a held high continuously, req_b raised during A's BUSY -> next grant goes to B, then A; strict alternation over 6 operations
//  mul_ready stuck 0, TIMEOUT_CYCLES=16 -> done_a and err_a together after 16 BUSY cycles;
//    result keeps its previous value; then IDLE
//  mul_ready left high from the previous operation -> no completion during ARM;
//    completes on the first BUSY cycle with the new product
//  reset=0 during BUSY -> all outputs 0 in the same cycle; no done; the first grant after reset release goes to A

Source files
------------

// File: rtl/mult_request_arbiter_if.sv
// Client and multiplier pins of the shared-multiplier arbiter.
// slave = arbiter view, master = client/multiplier side.
interface mult_request_arbiter_if #(
  parameter int WL = 6
);
  logic            req_a;
  logic [WL-1:0]   multiplicand_a;
  logic [WL-1:0]   multiplier_a;
  logic            req_b;
  logic [WL-1:0]   multiplicand_b;
  logic [WL-1:0]   multiplier_b;
  logic            gnt_a;
  logic            gnt_b;
  logic            done_a;
  logic            done_b;
  logic            err_a;
  logic            err_b;
  logic [2*WL-1:0] result;
  logic            busy;
  logic            mul_start;
  logic [WL-1:0]   mul_multiplicand;
  logic [WL-1:0]   mul_multiplier;
  logic            mul_ready;
  logic [2*WL-1:0] mul_product;

  modport slave (
    input  req_a, multiplicand_a, multiplier_a,
    input  req_b, multiplicand_b, multiplier_b,
    input  mul_ready, mul_product,
    output gnt_a, gnt_b, done_a, done_b,
    output err_a, err_b, result, busy,
    output mul_start, mul_multiplicand,
    output mul_multiplier
  );

  modport master (
    output req_a, multiplicand_a, multiplier_a,
    output req_b, multiplicand_b, multiplier_b,
    output mul_ready, mul_product,
    input  gnt_a, gnt_b, done_a, done_b,
    input  err_a, err_b, result, busy,
    input  mul_start, mul_multiplicand,
    input  mul_multiplier
  );
endinterface

// File: rtl/mult_request_arbiter.sv
// Round-robin sharing of one sequential multiplier
// between requesters A and B, with timeout abort.
module mult_request_arbiter #(
  parameter int Word_Length    = 6,
  parameter int ARM_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  mult_request_arbiter_if.slave bus
);
  localparam int WL = Word_Length;
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] ALOAD = AW'(ARM_CYCLES - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, ARM, BUSY, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            own_q, own_d;
  logic            last_q, last_d;
  logic [WL-1:0]   mcand_q, mcand_d;
  logic [WL-1:0]   mplier_q, mplier_d;
  logic [2*WL-1:0] result_q, result_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            gnt_a_q, gnt_a_d;
  logic            gnt_b_q, gnt_b_d;
  logic            done_a_q, done_a_d;
  logic            done_b_q, done_b_d;
  logic            err_a_q, err_a_d;
  logic            err_b_q, err_b_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            pick_a;

  // A wins if alone or if B owned the last operation
  assign pick_a = bus.req_a & (~bus.req_b | last_q);

  // Next state and registered outputs; owner B encoded as 1
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    acnt_d   = acnt_q;
    tcnt_d   = tcnt_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    err_a_d  = 1'b0;
    err_b_d  = 1'b0;
    start_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_a) begin
          own_d    = 1'b0;
          mcand_d  = bus.multiplicand_a;
          mplier_d = bus.multiplier_a;
          gnt_a_d  = 1'b1;
          start_d  = 1'b1;
          state_d  = LAUNCH;
        end else if (bus.req_b) begin
          own_d    = 1'b1;
          mcand_d  = bus.multiplicand_b;
          mplier_d = bus.multiplier_b;
          gnt_b_d  = 1'b1;
          start_d  = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        acnt_d  = ALOAD;
        state_d = ARM;
      end
      ARM: begin
        if (acnt_q == '0) begin
          tcnt_d  = '0;
          state_d = BUSY;
        end else begin
          acnt_d = acnt_q - AW'(1);
        end
      end
      BUSY: begin
        if (bus.mul_ready) begin
          result_d = bus.mul_product;
          done_a_d = ~own_q;
          done_b_d = own_q;
          state_d  = DONE;
        end else if (tcnt_q == TMAX) begin
          done_a_d = ~own_q;
          done_b_d = own_q;
          err_a_d  = ~own_q;
          err_b_d  = own_q;
          state_d  = DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DONE: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears all, last owner = B
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      acnt_q   <= '0;
      tcnt_q   <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      acnt_q   <= acnt_d;
      tcnt_q   <= tcnt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      err_a_q  <= err_a_d;
      err_b_q  <= err_b_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt_a            = gnt_a_q;
  assign bus.gnt_b            = gnt_b_q;
  assign bus.done_a           = done_a_q;
  assign bus.done_b           = done_b_q;
  assign bus.err_a            = err_a_q;
  assign bus.err_b            = err_b_q;
  assign bus.result           = result_q;
  assign bus.busy             = busy_q;
  assign bus.mul_start        = start_q;
  assign bus.mul_multiplicand = mcand_q;
  assign bus.mul_multiplier   = mplier_q;
endmodule
